i2s_rx: RTL and testbench

- Deserializer for the I2S stereo codec ADC stream; sits directly upstream of the delay core and produces its VALID, left_in and right_in inputs.
- Oversamples BCLK, LRCLK and SDATA in the system clock domain and assembles one 16-bit signed sample per channel.
- Presents each stereo frame atomically, with a one-cycle VALID strobe and a frame-error flag for misaligned or over-long slots.

---
 rtl/audio_pkg.sv | 21 ++
 rtl/sync_edge.sv | 43 ++++
 rtl/i2s_rx.sv | 146 ++++++++++++++
 tb/tb_i2s_rx.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio types for the I2S receive path
// Purpose: sample/stereo types and the I2S receiver state encoding.
// Ports: none (package).
package audio_pkg;

  localparam int AUDIO_W = 16;

  typedef logic signed [AUDIO_W-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } i2s_state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with registered edge detect
// Purpose: bring an asynchronous level into clk and flag its edges.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   din   in  asynchronous input
//   level out synchronized level (after 2 flops)
//   rise  out one-cycle pulse, registered, on a synchronized 0->1
//   fall  out one-cycle pulse, registered, on a synchronized 1->0
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
      // Edge pulses are registered so BCLK and LRCLK events line up with
      // each other at a fixed depth of three clk edges behind the pins.
      rise <= sync & ~prev;
      fall <= ~sync & prev;
    end
  end

  assign level = sync;

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S stereo deserializer producing atomic sample pairs
// Purpose: oversample BCLK/LRCLK/SDATA, capture one sample per slot and
//          present each complete left/right pair with a VALID strobe.
// Ports:
//   clk       in  system clock (>= 4x BCLK)
//   rst       in  synchronous active-high reset
//   BCLK      in  codec bit clock (async)
//   LRCLK     in  codec word select (async), 0 = left, 1 = right
//   SDATA     in  codec serial data, MSB first
//   left_in   out last complete left sample
//   right_in  out last complete right sample
//   VALID     out one-cycle strobe, new pair on left_in/right_in
//   frame_err out one-cycle strobe, current frame dropped
module i2s_rx
  import audio_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int SLOT_W    = 32,
  parameter int I2S_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              BCLK,
  input  logic              LRCLK,
  input  logic              SDATA,
  output logic [DATA_W-1:0] left_in,
  output logic [DATA_W-1:0] right_in,
  output logic              VALID,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] FIRST_BIT = CNT_W'(I2S_DELAY);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(I2S_DELAY + DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(I2S_DELAY + DATA_W);
  localparam logic [CNT_W-1:0] SAT_CNT   = CNT_W'(SLOT_W);

  logic bclk_lvl, bclk_rise, bclk_fall;
  logic lr_lvl, lr_rise, lr_fall;
  logic sd_lvl, sd_rise, sd_fall;

  sync_edge u_bclk (.clk(clk), .rst(rst), .din(BCLK),
                    .level(bclk_lvl), .rise(bclk_rise), .fall(bclk_fall));
  sync_edge u_lrclk (.clk(clk), .rst(rst), .din(LRCLK),
                     .level(lr_lvl), .rise(lr_rise), .fall(lr_fall));
  sync_edge u_sdata (.clk(clk), .rst(rst), .din(SDATA),
                     .level(sd_lvl), .rise(sd_rise), .fall(sd_fall));

  logic unused_sync;
  assign unused_sync = ^{bclk_lvl, bclk_fall, lr_lvl, sd_rise, sd_fall};

  i2s_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [DATA_W-1:0] left_shadow, shadow_n;
  logic [DATA_W-1:0] left_n, right_n;
  logic              valid_n, err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      left_shadow <= '0;
      left_in     <= '0;
      right_in    <= '0;
      VALID       <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      left_shadow <= shadow_n;
      left_in     <= left_n;
      right_in    <= right_n;
      VALID       <= valid_n;
      frame_err   <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shreg_n  = shreg;
    shadow_n = left_shadow;
    left_n   = left_in;
    right_n  = right_in;
    valid_n  = 1'b0;
    err_n    = 1'b0;

    // Slot boundaries are handled before the bit so that a bclk_rise in the
    // same cycle lands as bit 0 of the newly opened slot.
    case (state)
      IDLE: begin
        if (lr_fall) begin
          state_n = LEFT;
          cnt_n   = '0;
          shreg_n = '0;
        end
      end
      LEFT: begin
        if (lr_rise) begin
          cnt_n   = '0;
          shreg_n = '0;
          if (cnt >= FULL_CNT) begin
            shadow_n = shreg;
            state_n  = RIGHT;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      RIGHT: begin
        if (lr_fall) begin
          cnt_n   = '0;
          shreg_n = '0;
          state_n = LEFT;
          if (cnt >= FULL_CNT) begin
            left_n  = left_shadow;
            right_n = shreg;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (bclk_rise && state_n != IDLE) begin
      if (cnt_n == SAT_CNT) begin
        // Slot longer than SLOT_W: drop the frame and wait for a fresh left slot.
        err_n   = 1'b1;
        valid_n = 1'b0;
        state_n = IDLE;
      end else begin
        if (cnt_n >= FIRST_BIT && cnt_n <= LAST_BIT) begin
          shreg_n = {shreg_n[DATA_W-2:0], sd_lvl};
        end
        cnt_n = cnt_n + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - directed bench for the I2S deserializer
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        BCLK = 1'b0;
  logic        LRCLK = 1'b1;
  logic        SDATA = 1'b0;
  logic [15:0] left_in;
  logic [15:0] right_in;
  logic        VALID;
  logic        frame_err;

  i2s_rx dut (
    .clk(clk), .rst(rst), .BCLK(BCLK), .LRCLK(LRCLK), .SDATA(SDATA),
    .left_in(left_in), .right_in(right_in), .VALID(VALID), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lr_fall_cyc = 0;
  int both_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [15:0] l;
    logic [15:0] r;
    int          at;
    int          lat;
  } ev_t;

  ev_t evq[$];
  ev_t mon_e;

  // Event log sampled on the falling clk edge.
  always @(negedge clk) begin
    if (VALID && frame_err) both_cnt++;
    if (VALID || frame_err) begin
      mon_e.is_err = frame_err;
      mon_e.l      = left_in;
      mon_e.r      = right_in;
      mon_e.at     = cyc;
      mon_e.lat    = cyc - lr_fall_cyc;
      evq.push_back(mon_e);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One BCLK period of 8 clk: LRCLK/SDATA change with the falling BCLK.
  task automatic bit_cycle(input logic lr, input logic d);
    @(negedge clk);
    if (!lr && LRCLK) lr_fall_cyc = cyc;
    LRCLK = lr;
    SDATA = d;
    BCLK  = 1'b0;
    repeat (4) @(negedge clk);
    BCLK = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Bit 0 is the I2S delay bit, bits 1..16 carry the sample, rest are pad.
  task automatic send_slot(input logic lr, input int nbits, input logic [15:0] s, input logic pad);
    for (int k = 0; k < nbits; k++) begin
      if (k >= 1 && k <= 16) bit_cycle(lr, s[4'(16 - k)]);
      else bit_cycle(lr, pad);
    end
  endtask

  typedef struct {
    int          lbits;
    int          rbits;
    logic [15:0] l;
    logic [15:0] r;
    logic        pad;
    bit          exp_err;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];
  logic [15:0] f_l[4];
  logic [15:0] f_r[4];

  initial begin
    vecs[0] = '{32, 32, 16'h1234, 16'hABCD, 1'b0, 1'b0, 16'h1234, 16'hABCD, 4};
    vecs[1] = '{32, 32, 16'h8000, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 16'hFFFF, 4};
    vecs[2] = '{10, 32, 16'hAAAA, 16'h5555, 1'b0, 1'b1, 16'h8000, 16'hFFFF, 84};
    vecs[3] = '{32, 32, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0001, 16'h0002, 4};
    vecs[4] = '{40, 32, 16'h5555, 16'h1234, 1'b0, 1'b1, 16'h0001, 16'h0002, 264};
    vecs[5] = '{32, 32, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 16'h7FFF, 16'h0000, 4};
    f_l = '{16'h0102, 16'hFEDC, 16'h8001, 16'h7FFE};
    f_r = '{16'h0304, 16'hBA98, 16'h0000, 16'hFFFF};

    // Idle after reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", VALID, 1'b0);
    chk("reset_err", frame_err, 1'b0);
    repeat (40) @(negedge clk);
    chk("idle_left", left_in, 16'h0000);
    chk("idle_right", right_in, 16'h0000);
    chk("idle_events", evq.size(), 0);

    // Table-driven frames; the next frame's left slot closes the previous one.
    for (int i = 0; i < 6; i++) begin
      send_slot(1'b0, vecs[i].lbits, vecs[i].l, vecs[i].pad);
      send_slot(1'b1, vecs[i].rbits, vecs[i].r, vecs[i].pad);
    end
    send_slot(1'b0, 32, 16'h1111, 1'b0);

    chk("table_event_count", evq.size(), 6);
    for (int i = 0; i < 6 && i < evq.size(); i++) begin
      chk($sformatf("vec%0d_kind", i), evq[i].is_err, vecs[i].exp_err);
      chk($sformatf("vec%0d_left", i), evq[i].l, vecs[i].exp_l);
      chk($sformatf("vec%0d_right", i), evq[i].r, vecs[i].exp_r);
      chk($sformatf("vec%0d_latency", i), evq[i].lat, vecs[i].exp_lat);
    end

    // Reset in the middle of a right slot, then four back-to-back frames.
    evq.delete();
    send_slot(1'b1, 10, 16'h2222, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midreset_left", left_in, 16'h0000);
    chk("midreset_right", right_in, 16'h0000);
    chk("midreset_events", evq.size(), 0);
    send_slot(1'b1, 22, 16'h3333, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send_slot(1'b0, 32, f_l[i], 1'b0);
      send_slot(1'b1, 32, f_r[i], 1'b0);
    end
    send_slot(1'b0, 4, 16'h0000, 1'b0);
    repeat (8) @(negedge clk);

    chk("b2b_event_count", evq.size(), 4);
    for (int i = 0; i < 4 && i < evq.size(); i++) begin
      chk($sformatf("b2b%0d_kind", i), evq[i].is_err, 1'b0);
      chk($sformatf("b2b%0d_left", i), evq[i].l, f_l[i]);
      chk($sformatf("b2b%0d_right", i), evq[i].r, f_r[i]);
      chk($sformatf("b2b%0d_latency", i), evq[i].lat, 4);
      if (i > 0) chk($sformatf("b2b%0d_spacing", i), evq[i].at - evq[i-1].at, 512);
    end

    chk("valid_err_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
